uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchronised line, centre-sampled bits,
// one-clk rx_valid / rx_frame_err pulses and a BREAK state for held-low lines.
module uart_rx #(
    parameter int unsigned FRAME_BITS = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  baud_tick,
    input  logic                  rx_in,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_frame_err,
    output logic                  rx_busy
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_e;

    state_e                  state_q, state_d;
    logic                    sync1_q, sync1_d;
    logic                    sync2_q, sync2_d;
    logic [CNT_W-1:0]        sample_cnt_q, sample_cnt_d;
    logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [FRAME_BITS-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    rx_frame_err_q, rx_frame_err_d;
    logic                    rx_busy_q, rx_busy_d;
    logic                    rx_s;

    assign rx_s = sync2_q;

    // Next-state and output logic; everything advances only on baud_tick.
    always_comb begin
        state_d        = state_q;
        sync1_d        = rx_in;
        sync2_d        = sync1_q;
        sample_cnt_d   = sample_cnt_q;
        bit_idx_d      = bit_idx_q;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rx_frame_err_d = 1'b0;

        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d      = START;
                        sample_cnt_d = '0;
                    end
                end
                START: begin
                    if (sample_cnt_q == HALF_LAST) begin
                        sample_cnt_d = '0;
                        if (!rx_s) begin
                            state_d   = DATA;
                            bit_idx_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (sample_cnt_q == FULL_LAST) begin
                        for (int unsigned i = 0; i < FRAME_BITS; i++) begin
                            if (bit_idx_q == IDX_W'(i)) begin
                                shift_d[i] = rx_s;
                            end
                        end
                        sample_cnt_d = '0;
                        bit_idx_d    = bit_idx_q + IDX_W'(1);
                        if (bit_idx_q == LAST_BIT) begin
                            state_d = STOP;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (sample_cnt_q == FULL_LAST) begin
                        sample_cnt_d = '0;
                        if (rx_s) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            rx_frame_err_d = 1'b1;
                            state_d        = BREAK;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    end
                end
                BREAK: begin
                    // Wait for the line to release so a long break flags only once.
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        rx_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            sync1_q        <= 1'b1;
            sync2_q        <= 1'b1;
            sample_cnt_q   <= '0;
            bit_idx_q      <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rx_busy_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            sample_cnt_q   <= sample_cnt_d;
            bit_idx_q      <= bit_idx_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_frame_err_q <= rx_frame_err_d;
            rx_busy_q      <= rx_busy_d;
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_frame_err_q;
    assign rx_busy      = rx_busy_q;

endmodule
